// File: rtl/data_bus_responder.sv
// Data-port slave for the CPU core: zero-wait word RAM plus an MMIO page.
// The MMIO page holds a console TX FIFO, a free-running 64-bit cycle counter
// and a 64-bit timer compare that drives a registered timer interrupt.
module data_bus_responder #(
    parameter int          RAM_WORDS_LOG2 = 12,
    parameter logic [31:0] MMIO_BASE      = 32'h8000_0000,
    parameter int          TX_DEPTH_LOG2  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_wenable,
    output logic [31:0] data_rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        timer_irq
);

    localparam int RAM_WORDS = 2 ** RAM_WORDS_LOG2;
    localparam int TX_DEPTH  = 2 ** TX_DEPTH_LOG2;

    // MMIO word offsets (data_addr[7:2])
    localparam logic [5:0] OFF_CON_TX   = 6'h00;
    localparam logic [5:0] OFF_CON_STAT = 6'h01;
    localparam logic [5:0] OFF_CYCLE_LO = 6'h02;
    localparam logic [5:0] OFF_CYCLE_HI = 6'h03;
    localparam logic [5:0] OFF_CMP_LO   = 6'h04;
    localparam logic [5:0] OFF_CMP_HI   = 6'h05;

    localparam logic [TX_DEPTH_LOG2:0]   LP_CNT_FULL = (TX_DEPTH_LOG2+1)'(TX_DEPTH);
    localparam logic [TX_DEPTH_LOG2:0]   LP_CNT_ONE  = (TX_DEPTH_LOG2+1)'(1);
    localparam logic [TX_DEPTH_LOG2-1:0] LP_PTR_ONE  = TX_DEPTH_LOG2'(1);

    // Storage and state
    logic [31:0]              r_ram [RAM_WORDS];
    logic [7:0]               r_fifo [TX_DEPTH];
    logic [TX_DEPTH_LOG2-1:0] r_wptr;
    logic [TX_DEPTH_LOG2-1:0] r_rptr;
    logic [TX_DEPTH_LOG2:0]   r_count;
    logic                     r_ovf;
    logic [63:0]              r_cycle;
    logic [63:0]              r_cmp;
    logic                     r_irq;

    // Decode
    logic                      w_ram_sel;
    logic                      w_mmio_sel;
    logic [RAM_WORDS_LOG2-1:0] w_ram_idx;
    logic [5:0]                w_off;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_pop;
    logic                      w_push_req;
    logic                      w_push;
    logic                      w_stat_w1c;
    logic [31:0]               w_rdata;
    logic                      w_unused;

    assign w_ram_sel  = (data_addr[31:RAM_WORDS_LOG2+2] == '0);
    assign w_mmio_sel = (data_addr[31:8] == MMIO_BASE[31:8]);
    assign w_ram_idx  = data_addr[RAM_WORDS_LOG2+1:2];
    assign w_off      = data_addr[7:2];
    assign w_unused   = ^data_addr[1:0];

    assign w_full     = (r_count == LP_CNT_FULL);
    assign w_empty    = (r_count == '0);
    assign w_pop      = !w_empty && tx_ready;
    assign w_push_req = w_mmio_sel && (w_off == OFF_CON_TX) && data_wenable[0];
    // A full FIFO can still take a byte when the sink frees a slot this cycle.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_stat_w1c = w_mmio_sel && (w_off == OFF_CON_STAT) && data_wenable[0]
                        && data_wdata[2];

    // RAM byte-lane writes; reset suppresses the write but does not clear contents
    // NOTE: large memories are never reset -- clearing them would force flops instead of RAM macros.
    always_ff @(posedge clk) begin
        if (rst_n && w_ram_sel) begin
            for (int i = 0; i < 4; i++) begin
                if (data_wenable[i]) begin
                    r_ram[w_ram_idx][8*i +: 8] <= data_wdata[8*i +: 8];
                end
            end
        end
    end

    // Console FIFO storage (contents only; validity is tracked by the count)
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_fifo[r_wptr] <= data_wdata[7:0];
        end
    end

    // Console FIFO pointers, occupancy and sticky overflow flag
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + LP_PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + LP_PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + LP_CNT_ONE;
                2'b01:   r_count <= r_count - LP_CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_push_req && !w_push) begin
                r_ovf <= 1'b1;
            end else if (w_stat_w1c) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Cycle counter, timer compare register and registered interrupt
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cycle <= '0;
            r_cmp   <= '1;
            r_irq   <= 1'b0;
        end else begin
            r_cycle <= r_cycle + 64'd1;
            r_irq   <= (r_cycle >= r_cmp);
            if (w_mmio_sel && (w_off == OFF_CMP_LO)) begin
                for (int i = 0; i < 4; i++) begin
                    if (data_wenable[i]) r_cmp[8*i +: 8] <= data_wdata[8*i +: 8];
                end
            end
            if (w_mmio_sel && (w_off == OFF_CMP_HI)) begin
                for (int i = 0; i < 4; i++) begin
                    if (data_wenable[i]) r_cmp[32+8*i +: 8] <= data_wdata[8*i +: 8];
                end
            end
        end
    end

    // Side-effect-free read mux
    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_rdata = '0;
        if (w_ram_sel) begin
            w_rdata = r_ram[w_ram_idx];
        end else if (w_mmio_sel) begin
            case (w_off)
                OFF_CON_STAT: w_rdata = {16'h0000, 8'(r_count), 5'b0, r_ovf, w_empty, w_full};
                OFF_CYCLE_LO: w_rdata = r_cycle[31:0];
                OFF_CYCLE_HI: w_rdata = r_cycle[63:32];
                OFF_CMP_LO:   w_rdata = r_cmp[31:0];
                OFF_CMP_HI:   w_rdata = r_cmp[63:32];
                default:      w_rdata = '0;
            endcase
        end
    end

    assign data_rdata = w_rdata;
    assign tx_data    = r_fifo[r_rptr];
    assign tx_valid   = !w_empty;
    assign timer_irq  = r_irq;

endmodule

// File: tb/tb_data_bus_responder.sv
// Self-checking bench for data_bus_responder: directed scenarios plus random
// traffic, compared every cycle against a transaction-level model.
module tb_data_bus_responder;

    localparam logic [31:0] A_TX   = 32'h8000_0000;
    localparam logic [31:0] A_STAT = 32'h8000_0004;
    localparam logic [31:0] A_CLO  = 32'h8000_0008;
    localparam logic [31:0] A_CHI  = 32'h8000_000C;
    localparam logic [31:0] A_MLO  = 32'h8000_0010;
    localparam logic [31:0] A_MHI  = 32'h8000_0014;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wenable;
    logic [31:0] data_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        timer_irq;

    data_bus_responder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_wenable (data_wenable),
        .data_rdata   (data_rdata),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .timer_irq    (timer_irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0]     m_ram [int unsigned];
    logic [7:0]      m_q [$];
    bit              m_ovf;
    longint unsigned m_cyc;
    longint unsigned m_cmp;
    bit              m_irq;
    bit              chk_en = 1'b0;

    // Values observed during the most recent step
    logic [31:0] last_rd;
    logic        last_valid;
    logic [7:0]  last_txd;
    logic        last_irq;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a, output bit known);
        int unsigned sz = m_q.size();
        known = 1'b1;
        if (a < 32'h0000_4000) begin
            known = m_ram.exists(a >> 2);
            return known ? m_ram[a >> 2] : 32'h0;
        end
        if (a[31:8] != 24'h80_0000) return 32'h0;
        case (a[7:2])
            6'h01:   return {16'h0, 8'(sz), 5'b0, m_ovf, (sz == 0), (sz == 16)};
            6'h02:   return m_cyc[31:0];
            6'h03:   return m_cyc[63:32];
            6'h04:   return m_cmp[31:0];
            6'h05:   return m_cmp[63:32];
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_update(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                            input logic rdy, input logic rst);
        int sz;
        bit pop, mm, irq_n;
        if (!rst) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_cyc = 0;
            m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
            m_irq = 1'b0;
            return;
        end
        sz    = m_q.size();
        pop   = (sz > 0) && rdy;
        mm    = (a[31:8] == 24'h80_0000);
        irq_n = (m_cyc >= m_cmp);
        if (pop) void'(m_q.pop_front());
        if (mm && a[7:2] == 6'h00 && we[0]) begin
            if (sz < 16 || pop) m_q.push_back(wd[7:0]);
            else m_ovf = 1'b1;
        end
        if (mm && a[7:2] == 6'h01 && we[0] && wd[2]) m_ovf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                if (mm && a[7:2] == 6'h04) m_cmp[8*i +: 8] = wd[8*i +: 8];
                if (mm && a[7:2] == 6'h05) m_cmp[32+8*i +: 8] = wd[8*i +: 8];
                if (a < 32'h0000_4000) begin
                    logic [31:0] w = m_ram.exists(a >> 2) ? m_ram[a >> 2] : 32'hx;
                    w[8*i +: 8] = wd[8*i +: 8];
                    m_ram[a >> 2] = w;
                end
            end
        end
        m_cyc = m_cyc + 1;
        m_irq = irq_n;
    endtask

    // One bus cycle: drive at negedge, compare just after, then advance the model at posedge.
    task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                        input logic rdy, input logic rst);
        logic [31:0] exp;
        bit known;
        @(negedge clk);
        data_addr = a; data_wdata = wd; data_wenable = we; tx_ready = rdy; rst_n = rst;
        #1;
        last_rd = data_rdata; last_valid = tx_valid; last_txd = tx_data; last_irq = timer_irq;
        if (chk_en) begin
            exp = m_read(a, known);
            if (known) check("rdata", data_rdata, exp);
            check("tx_valid", {31'b0, tx_valid}, {31'b0, (m_q.size() > 0)});
            if (m_q.size() > 0) check("tx_data", {24'b0, tx_data}, {24'b0, m_q[0]});
            check("timer_irq", {31'b0, timer_irq}, {31'b0, m_irq});
        end
        @(posedge clk);
        m_update(a, wd, we, rdy, rst);
        if (!rst) chk_en = 1'b1;
    endtask

    task automatic do_reset();
        step(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, wd;
        logic [3:0]  we;
        data_addr = '0; data_wdata = '0; data_wenable = '0; tx_ready = 1'b0; rst_n = 1'b0;
        do_reset();
        do_reset();

        // Reset state
        step(A_STAT, 0, 4'h0, 1'b0, 1'b1);
        check("rst_stat", last_rd, 32'h0000_0002);
        check("rst_valid", {31'b0, last_valid}, 32'h0);
        step(A_MHI, 0, 4'h0, 1'b0, 1'b1);
        check("rst_cmp_hi", last_rd, 32'hFFFF_FFFF);

        // 1: RAM byte-lane writes
        step(32'h100, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b1);
        step(32'h100, 32'h0000_AA00, 4'h2, 1'b0, 1'b1);
        step(32'h100, 0, 4'h0, 1'b0, 1'b1);
        check("t1_word", last_rd, 32'hDEAD_AAEF);
        step(32'h101, 0, 4'h0, 1'b0, 1'b1);
        check("t1_unaligned", last_rd, 32'hDEAD_AAEF);
        step(32'h4000_0000, 0, 4'h0, 1'b0, 1'b1);
        check("t1_unmapped", last_rd, 32'h0);

        // 2: overflow on full FIFO, then ordered drain
        do_reset();
        for (int i = 0; i < 17; i++) step(A_TX, i, 4'h1, 1'b0, 1'b1);
        step(A_STAT, 0, 4'h0, 1'b0, 1'b1);
        check("t2_stat_full", last_rd, 32'h0000_1005);
        for (int i = 0; i < 16; i++) begin
            step(A_TX, 0, 4'h0, 1'b1, 1'b1);
            check("t2_drain", {24'b0, last_txd}, i);
        end
        step(A_STAT, 0, 4'h0, 1'b0, 1'b1);
        check("t2_empty_valid", {31'b0, last_valid}, 32'h0);
        check("t2_stat_empty", last_rd, 32'h0000_0006);

        // 6: W1C of overflow needs wenable[0]
        step(A_STAT, 32'h4, 4'h0, 1'b0, 1'b1);
        step(A_STAT, 0, 4'h0, 1'b0, 1'b1);
        check("t6_no_we", {31'b0, last_rd[2]}, 32'h1);
        step(A_STAT, 32'h4, 4'h1, 1'b0, 1'b1);
        step(A_STAT, 0, 4'h0, 1'b0, 1'b1);
        check("t6_w1c", {31'b0, last_rd[2]}, 32'h0);

        // 3: push into a full FIFO while the sink pops
        do_reset();
        for (int i = 0; i < 16; i++) step(A_TX, i, 4'h1, 1'b0, 1'b1);
        step(A_TX, 32'h55, 4'h1, 1'b1, 1'b1);
        step(A_STAT, 0, 4'h0, 1'b0, 1'b1);
        check("t3_stat", last_rd, 32'h0000_1001);
        for (int i = 0; i < 16; i++) begin
            step(A_TX, 0, 4'h0, 1'b1, 1'b1);
            check("t3_drain", {24'b0, last_txd}, (i == 15) ? 32'h55 : i + 1);
        end

        // 4: timer compare
        do_reset();
        step(A_MHI, 32'h0, 4'hF, 1'b0, 1'b1);
        step(A_MLO, 32'd20, 4'hF, 1'b0, 1'b1);
        for (int i = 0; i < 30; i++) begin
            step(A_CLO, 0, 4'h0, 1'b0, 1'b1);
            check("t4_irq_vs_cycle", {31'b0, last_irq}, {31'b0, (last_rd >= 32'd21)});
        end
        step(A_MLO, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b1);
        step(A_MHI, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b1);
        check("t4_irq_still_high", {31'b0, last_irq}, 32'h1);
        step(A_CLO, 0, 4'h0, 1'b0, 1'b1);
        check("t4_irq_fell", {31'b0, last_irq}, 32'h0);

        // 5: reset mid-drain with overflow set, colliding with a RAM write
        do_reset();
        for (int i = 0; i < 17; i++) step(A_TX, i, 4'h1, 1'b0, 1'b1);
        for (int i = 0; i < 11; i++) step(A_TX, 0, 4'h0, 1'b1, 1'b1);
        step(32'h100, 32'h1234_5678, 4'hF, 1'b1, 1'b0);
        step(A_CLO, 0, 4'h0, 1'b0, 1'b1);
        check("t5_valid", {31'b0, last_valid}, 32'h0);
        check("t5_cycle", last_rd, 32'h0);
        step(A_STAT, 0, 4'h0, 1'b0, 1'b1);
        check("t5_stat", last_rd, 32'h0000_0002);
        step(32'h100, 0, 4'h0, 1'b0, 1'b1);
        check("t5_ram_kept", last_rd, 32'hDEAD_AAEF);

        // Random traffic against the model
        for (int i = 0; i < 16; i++) step(32'h100 + 4 * i, $urandom, 4'hF, 1'b0, 1'b1);
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: a = 32'h100 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
                9:       a = ($urandom_range(0, 1) != 0) ? 32'h4000 + 4 * $urandom_range(0, 255)
                                                         : 32'h9000_0000 + $urandom_range(0, 255);
                default: a = A_TX + 4 * $urandom_range(0, 7) + $urandom_range(0, 3);
            endcase
            we = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(0, 15));
            wd = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 800) : $urandom;
            step(a, wd, we, ($urandom_range(0, 9) < 3), ($urandom_range(0, 99) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
